data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder (slave) side of the processor's data-memory interface. The datapath initiates a load or store using the ALU result as the address and the rs2 read value as the write data.
- This block accepts the request with a valid/ready handshake and inserts a configurable number of wait states.
- It then commits the write, or samples the read, on a word-addressed array and returns the read data or an error with a second handshake.
- It replaces the zero-latency combinational data memory, so the multi-cycle core can stall on memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
BASE_ADDR, 32'h10010000, byte address of word 0 (MIPS data segment).
LATENCY, 2, number of wait cycles inserted before the access (0..15).

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  initiator has a request.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store word, 0 = load word.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
resp_valid  output  1  response available.
resp_ready  input  1  initiator accepts the response.
resp_rdata  output  32  load data; 0 for stores and errors.
resp_error  output  1  misaligned or out-of-range access.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, counter=0, request latches cleared. Array contents are not reset.
- States: IDLE, BUSY, RESP. Encoding is one-hot or binary, with the encoding held in the package.
- IDLE:
  - req_ready=1.
  - Acceptance occurs on an edge where req_valid && req_ready.
  - On acceptance, latch req_write, req_addr and req_wdata; load counter with LATENCY; go to BUSY.
  - Request inputs are ignored outside acceptance edges.
- BUSY:
  - req_ready=0.
  - If counter != 0, decrement.
  - If counter == 0, perform the access and go to RESP. BUSY therefore lasts exactly LATENCY+1 cycles.
- Access, at the BUSY→RESP edge:
  - err = (addr[1:0] != 0) || (addr < BASE_ADDR) || (addr >= BASE_ADDR + 4*DEPTH_WORDS). Use 33-bit arithmetic for the upper bound so a high BASE_ADDR does not wrap.
  - Index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
  - Store with no error: array[index] <= wdata; resp_rdata=0.
  - Load with no error: resp_rdata <= array[index], the value before any same-edge write.
  - Any error: no array write, resp_rdata=0, resp_error=1.
- RESP:
  - resp_valid=1. resp_rdata and resp_error are held stable while resp_valid && !resp_ready.
  - On resp_ready: go to IDLE and clear resp_valid, resp_error and resp_rdata. req_ready returns the following cycle, so the minimum request-to-request spacing is LATENCY+3 cycles.
- Latency: the first resp_valid=1 cycle is LATENCY+1 cycles after the acceptance edge.
- resp_ready=1 while not in RESP has no effect. req_valid dropping during BUSY or RESP has no effect, because the request was already captured.
- Reset mid-operation:
  - Reset asserted in BUSY before the access edge aborts the transaction; no write occurs.
  - Reset in RESP discards the response; the write, if any, has already committed.
  - Outputs return to reset values immediately, since the reset is asynchronous.
- Load-after-store to the same word in back-to-back transactions returns the new data.

Decomposition:
- Package data_mem_pkg:
  - State enumeration (IDLE/BUSY/RESP).
  - Default BASE_ADDR constant.
  - Localparam helpers: index width = clog2(DEPTH_WORDS); counter width = 4.
  - Address-check function returning err.
- Sub-module word_ram (DEPTH_WORDS x 32, one synchronous write port, one synchronous read port, no reset) holds the array.
- The FSM, counter and response registers live in data_memory_responder.

Test Plan:
1. LATENCY=2: store 0xDEADBEEF to 0x10010008, resp_ready=1 → resp_valid exactly 3 cycles after acceptance with resp_error=0, resp_rdata=0. Then load 0x10010008 → resp_rdata=0xDEADBEEF, resp_error=0.
2. Misaligned load at 0x10010006, and store 0x12345678 to 0x1001000A → resp_error=1, resp_rdata=0. A subsequent load of 0x10010008 still returns 0xDEADBEEF.
3. Out-of-range addresses: 0x1000FFFC (below BASE_ADDR) and 0x10011000 (equal to BASE_ADDR+4*1024) → resp_error=1. Address 0x10010FFC (last word) stores and reloads 0x0000CAFE with no error.
4. Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_valid, resp_rdata and resp_error stay constant and req_ready=0. A req_valid pulse during this window is not accepted. Release → resp_valid falls and req_ready=1 on the next cycle.
5. Reset during BUSY of a store of 0xAAAAAAAA to 0x10010010, with 0x11111111 preloaded → outputs reset immediately. The following load of 0x10010010 returns 0x11111111.
6. LATENCY=0 build: back-to-back store 0x00000001 then load at 0x10010000 → each response 1 cycle after acceptance; the load returns 0x00000001; spacing is 3 cycles.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the data-memory responder.
package data_mem_pkg;

    // FSM encoding (binary).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // MIPS data segment start.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    // Wait-state counter width, which covers LATENCY values 0..15.
    localparam int unsigned CNT_W = 4;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Misaligned or outside [base, base+span). The upper bound is computed in
    // 33 bits so that a window ending at 4 GiB does not wrap to zero.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [32:0] span);
        logic [32:0] limit;
        limit = {1'b0, base} + span;
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/data_memory_responder_word_ram.sv
// Word-wide storage array: one synchronous write port, one registered read port, no reset.
module word_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Write commit and read sample; a same-edge read returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: valid/ready request, LATENCY wait states, then
// a single access to the word array and a held response until accepted.
module data_memory_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             load_q, load_d;

    logic             acc_err;
    logic             access;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [31:0]      ram_rdata;

    assign acc_err = addr_error(addr_q, BASE_ADDR, SPAN);
    assign offset  = addr_q - BASE_ADDR;
    assign idx     = IDX_W'(offset >> 2);

    // Next-state logic for the handshake FSM, wait counter and response flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        load_d  = load_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access  = 1'b1;
                    err_d   = acc_err;
                    load_d  = !write_q && !acc_err;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    err_d   = 1'b0;
                    load_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset; array contents are untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (access && write_q && !acc_err),
        .waddr_i (idx),
        .wdata_i (wdata_q),
        .re_i    (access && !write_q && !acc_err),
        .raddr_i (idx),
        .rdata_o (ram_rdata)
    );

    // The RAM read register is only loaded on a good load, so gating it with
    // load_q gives zero for stores, errors, idle and reset.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_error = err_q;
    assign resp_rdata = load_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (LATENCY=2 and LATENCY=0 instances).
module tb_data_memory_responder;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Instance A: LATENCY=2
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;
    // Instance B: LATENCY=0
    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_ready, b_resp_error;
    logic [31:0] b_resp_rdata;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;

    data_memory_responder #(.LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    data_memory_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected expected response (t=%0t)", name, $time);
    endtask

    // Monitor A: latency on first valid cycle, data/error on handshake.
    always @(negedge clk) begin
        if (resp_valid && !a_prev) begin
            if (qa.size() == 0) fail_now("a_unexpected_resp");
            else check("a_latency", cyc - qa[0].acc, 32'd3);
        end
        if (resp_valid && resp_ready && qa.size() > 0) begin
            ea = qa.pop_front();
            check("a_rdata", resp_rdata, ea.rd);
            check("a_error", {31'd0, resp_error}, {31'd0, ea.err});
        end
        a_prev <= resp_valid;
    end

    // Monitor B.
    always @(negedge clk) begin
        if (b_resp_valid && !b_prev) begin
            if (qb.size() == 0) fail_now("b_unexpected_resp");
            else check("b_latency", cyc - qb[0].acc, 32'd1);
        end
        if (b_resp_valid && b_resp_ready && qb.size() > 0) begin
            eb = qb.pop_front();
            check("b_rdata", b_resp_rdata, eb.rd);
            check("b_error", {31'd0, b_resp_error}, {31'd0, eb.err});
        end
        b_prev <= b_resp_valid;
    end

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic req_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] erd, input logic eerr, input bit wait_done);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin fail_now("a_req_ready_timeout"); return; end
        qa.push_back('{erd, eerr, cyc + 1});
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (wait_done) begin
            n = 0;
            while (qa.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
            if (qa.size() != 0) begin fail_now("a_resp_timeout"); qa.delete(); end
        end
    endtask

    task automatic req_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] erd, input logic eerr, output int acc);
        int n;
        n = 0;
        acc = 0;
        while (!b_req_ready && n < 40) begin @(posedge clk); #1; n++; end
        if (!b_req_ready) begin fail_now("b_req_ready_timeout"); return; end
        acc = cyc + 1;
        qb.push_back('{erd, eerr, cyc + 1});
        b_req_valid = 1'b1; b_req_write = w; b_req_addr = a; b_req_wdata = d;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc1, acc2;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", {31'd0, resp_error}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // 1: store then load
        req_a(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        req_a(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        // 2: misaligned
        req_a(1'b0, 32'h1001_0006, 32'h0, 32'h0, 1'b1, 1'b1);
        req_a(1'b1, 32'h1001_000A, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
        req_a(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        // 3: range boundaries
        req_a(1'b0, 32'h1000_FFFC, 32'h0, 32'h0, 1'b1, 1'b1);
        req_a(1'b1, 32'h1001_1000, 32'h7777_7777, 32'h0, 1'b1, 1'b1);
        req_a(1'b1, 32'h1001_0FFC, 32'h0000_CAFE, 32'h0, 1'b0, 1'b1);
        req_a(1'b0, 32'h1001_0FFC, 32'h0, 32'h0000_CAFE, 1'b0, 1'b1);

        // 4: back-pressure
        resp_ready = 1'b0;
        req_a(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        if (!resp_valid) fail_now("bp_resp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
            check("bp_resp_error", {31'd0, resp_error}, 32'd0);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            if (i == 1) begin
                req_valid = 1'b1; req_write = 1'b1;
                req_addr = 32'h1001_0008; req_wdata = 32'h5555_5555;
            end
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_a(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // 5: reset during BUSY aborts the store
        req_a(1'b1, 32'h1001_0010, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1001_0010; req_wdata = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("busy_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_resp_rdata", resp_rdata, 32'd0);
        check("midrst_resp_error", {31'd0, resp_error}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk); #1;
        req_a(1'b0, 32'h1001_0010, 32'h0, 32'h1111_1111, 1'b0, 1'b1);

        // 6: LATENCY=0 back-to-back
        req_b(1'b1, 32'h1001_0000, 32'h0000_0001, 32'h0, 1'b0, acc1);
        req_b(1'b0, 32'h1001_0000, 32'h0, 32'h0000_0001, 1'b0, acc2);
        check("b_spacing", acc2 - acc1, 32'd3);
        n = 0;
        while (qb.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
        if (qb.size() != 0) fail_now("b_resp_timeout");

        @(posedge clk); @(posedge clk); #1;
        check("a_queue_drained", qa.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
